// File: rtl/ftdnn_requant_pkg.sv
// Shared width constants and pair types for the requantizer arbiter slice.
package ftdnn_requant_pkg;

    localparam int NUM_REQ_DEF      = 4;
    localparam int WID_DATA_IN_DEF  = 32;
    localparam int WID_DATA_OUT_DEF = 8;
    localparam int OUT_DEPTH_DEF    = 2;
    localparam int WID_ID_DEF       = $clog2(NUM_REQ_DEF);

    typedef logic [WID_ID_DEF-1:0]         req_id_t;
    typedef logic [2*WID_DATA_IN_DEF-1:0]  acc_pair_t;
    typedef logic [2*WID_DATA_OUT_DEF-1:0] q_pair_t;

endpackage

// File: rtl/pseudo_round.sv
// Two-lane pseudo-rounding requantizer: keeps the top bits of each lane and rounds up
// when the upper half of the discarded field exceeds the lower half. One-cycle latency.
module pseudo_round #(
    parameter int WID_DATA_IN  = 32,
    parameter int WID_DATA_OUT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [2*WID_DATA_IN-1:0]  in_data,
    output logic [2*WID_DATA_OUT-1:0] out_data
);

    localparam int SH = WID_DATA_IN - WID_DATA_OUT;
    localparam int HF = SH / 2;
    localparam int CW = SH - HF;

    logic [2*WID_DATA_OUT-1:0] rnd;

    for (genvar l = 0; l < 2; l++) begin : g_lane
        logic [WID_DATA_IN-1:0] x;
        logic [CW-1:0]          hi_part;
        logic [CW-1:0]          lo_part;

        assign x       = in_data[l*WID_DATA_IN +: WID_DATA_IN];
        assign hi_part = x[SH-1:HF];
        assign lo_part = CW'(x[HF-1:0]);
        assign rnd[l*WID_DATA_OUT +: WID_DATA_OUT] =
            x[WID_DATA_IN-1:SH] + WID_DATA_OUT'(hi_part > lo_part);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
        end else begin
            out_data <= rnd;
        end
    end

endmodule

// File: rtl/requant_arbiter.sv
// Round-robin sharing of one pseudo_round requantizer among NUM_REQ accumulator drains,
// with in-flight tag tracking and a small credit-protected output FIFO.
module requant_arbiter
    import ftdnn_requant_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEF,
    parameter int WID_DATA_IN  = WID_DATA_IN_DEF,
    parameter int WID_DATA_OUT = WID_DATA_OUT_DEF,
    parameter int OUT_DEPTH    = OUT_DEPTH_DEF
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ*2*WID_DATA_IN-1:0]   req_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [2*WID_DATA_OUT-1:0]          out_data,
    output logic [$clog2(NUM_REQ)-1:0]         out_id,
    output logic                               busy
);

    localparam int WID_ID = $clog2(NUM_REQ);
    localparam int PW     = $clog2(OUT_DEPTH);
    localparam int CW     = PW + 1;
    localparam int AW     = 2 * WID_DATA_IN;
    localparam int QW     = 2 * WID_DATA_OUT;

    logic [WID_ID-1:0] rr_q;
    logic [WID_ID-1:0] grant;
    logic              grant_v;
    logic              allow;
    logic              accept;
    logic              push;
    logic              pop;
    logic [CW:0]       occupancy;

    logic              inflight_v_q;
    logic [WID_ID-1:0] inflight_id_q;

    logic [AW-1:0]     round_in;
    logic [QW-1:0]     round_out;

    logic [CW-1:0]     count_q;
    logic [PW-1:0]     wr_ptr_q;
    logic [PW-1:0]     rd_ptr_q;
    logic [QW-1:0]     data_mem [OUT_DEPTH];
    logic [WID_ID-1:0] id_mem   [OUT_DEPTH];

    assign out_valid = (count_q != '0);
    assign pop       = out_valid & out_ready;
    assign push      = inflight_v_q;

    // A same-cycle pop frees a slot, so it is credited before deciding to issue.
    assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_v_q) - (CW+1)'(pop);
    assign allow     = occupancy < (CW+1)'(OUT_DEPTH);

    always_comb begin
        int unsigned idx;
        grant   = '0;
        grant_v = 1'b0;
        idx     = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(rr_q) + off) % NUM_REQ;
            if (!grant_v && req_valid[idx]) begin
                grant_v = 1'b1;
                grant   = WID_ID'(idx);
            end
        end
    end

    assign accept    = allow & grant_v;
    assign req_ready = accept ? (NUM_REQ'(1) << grant) : '0;
    assign round_in  = accept ? req_data[grant*AW +: AW] : '0;

    pseudo_round #(
        .WID_DATA_IN  (WID_DATA_IN),
        .WID_DATA_OUT (WID_DATA_OUT)
    ) u_round (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (round_in),
        .out_data (round_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q          <= '0;
            inflight_v_q  <= 1'b0;
            inflight_id_q <= '0;
        end else begin
            inflight_v_q  <= accept;
            inflight_id_q <= grant;
            if (accept) begin
                rr_q <= (grant == WID_ID'(NUM_REQ-1)) ? '0 : grant + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < OUT_DEPTH; i++) begin
                data_mem[i] <= '0;
                id_mem[i]   <= '0;
            end
        end else begin
            if (push) begin
                data_mem[wr_ptr_q] <= round_out;
                id_mem[wr_ptr_q]   <= inflight_id_q;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_data = data_mem[rd_ptr_q];
    assign out_id   = id_mem[rd_ptr_q];
    assign busy     = inflight_v_q | (count_q != '0);

    // The issue credit must make a push into a full FIFO unreachable.
    assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && count_q == CW'(OUT_DEPTH)))
        else $error("requant_arbiter: push into full output FIFO");

endmodule
